// File: rtl/vote_collector.sv
// ---------------------------------------------------------------------------
// vote_collector
//
// Purpose:
//   Upstream stage of the 4-voter majority block. Opens a timed voting
//   window on i_start, locks each voter's first ballot (rising edge of
//   i_vote_req[i] samples i_vote_val[i]), and presents the completed
//   ballot vector with a valid/ack handshake. Missing voters count as "no".
//
// Parameters:
//   WINDOW_CYCLES  voting window length in OPEN cycles (2 .. 2**CNT_W)
//   CNT_W          width of the window down-counter
//
// Ports:
//   i_clk           system clock, rising edge
//   i_rst_n         asynchronous active-low reset
//   i_start         opens a round (honoured only in IDLE)
//   i_vote_req[3:0] per-voter cast strobe; a cast is a rising edge
//   i_vote_val[3:0] per-voter choice, sampled on the req rising edge
//   i_result_ack    consumer has taken the ballot (honoured only in DONE)
//   o_ballot[3:0]   locked ballot vector, bit i = voter i, 1 = yes
//   o_ballot_valid  ballot is complete and stable
//   o_cast_mask[3:0] bit i set once voter i has cast this round
//   o_busy          high in OPEN and DONE
//   o_timed_out     round closed by window expiry with a voter missing
// ---------------------------------------------------------------------------
module vote_collector #(
  parameter int WINDOW_CYCLES = 1000,
  parameter int CNT_W         = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [3:0]       i_vote_req,
  input  logic [3:0]       i_vote_val,
  input  logic             i_result_ack,
  output logic [3:0]       o_ballot,
  output logic             o_ballot_valid,
  output logic [3:0]       o_cast_mask,
  output logic             o_busy,
  output logic             o_timed_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OPEN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [3:0]       r_ballot;
  logic             r_ballot_valid;
  logic [3:0]       r_cast_mask;
  logic             r_busy;
  logic             r_timed_out;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_req_prev;

  logic [3:0]       w_cast_edge;
  logic [3:0]       w_accept;
  logic [3:0]       w_next_mask;
  logic [3:0]       w_next_ballot;

  // Only a fresh rising edge from a voter who has not yet cast is accepted.
  assign w_cast_edge   = i_vote_req & ~r_req_prev;
  assign w_accept      = w_cast_edge & ~r_cast_mask;
  assign w_next_mask   = r_cast_mask | w_accept;
  assign w_next_ballot = (r_ballot & ~w_accept) | (i_vote_val & w_accept);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      r_ballot       <= 4'b0000;
      r_ballot_valid <= 1'b0;
      r_cast_mask    <= 4'b0000;
      r_busy         <= 1'b0;
      r_timed_out    <= 1'b0;
      r_cnt          <= '0;
      // All-ones so a button held through reset is not seen as a cast.
      r_req_prev     <= 4'b1111;
    end else begin
      r_req_prev <= i_vote_req;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state     <= S_OPEN;
            r_busy      <= 1'b1;
            r_cast_mask <= 4'b0000;
            r_ballot    <= 4'b0000;
            r_timed_out <= 1'b0;
            // Counter runs WINDOW_CYCLES-1 .. 0: exactly WINDOW_CYCLES cycles.
            r_cnt       <= CNT_W'(WINDOW_CYCLES - 1);
          end
        end
        S_OPEN: begin
          r_ballot    <= w_next_ballot;
          r_cast_mask <= w_next_mask;
          r_cnt       <= r_cnt - CNT_W'(1);
          // Full turnout wins over expiry when both happen in one cycle.
          if (w_next_mask == 4'b1111) begin
            r_state        <= S_DONE;
            r_ballot_valid <= 1'b1;
            r_timed_out    <= 1'b0;
          end else if (r_cnt == '0) begin
            r_state        <= S_DONE;
            r_ballot_valid <= 1'b1;
            r_timed_out    <= 1'b1;
          end
        end
        S_DONE: begin
          if (i_result_ack) begin
            r_state        <= S_IDLE;
            r_busy         <= 1'b0;
            r_ballot_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_ballot       = r_ballot;
  assign o_ballot_valid = r_ballot_valid;
  assign o_cast_mask    = r_cast_mask;
  assign o_busy         = r_busy;
  assign o_timed_out    = r_timed_out;

endmodule
